// File: rtl/demo_pkg.sv
// Shared types and constants for the demo counter designs.
package demo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  // All-ones value of a w-bit field (w up to 16).
  function automatic logic [15:0] reload_rst(input int w);
    return 16'((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/dff_sync_n.sv
// W-bit register with synchronous active-low reset to a parameterised value.
module dff_sync_n #(
  parameter int             W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/down_cnt_timer.sv
// Loadable down-counter/timer with auto-reload and a busy/done handshake.
module down_cnt_timer
  import demo_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         auto_reload,
  output logic [W-1:0] counter,
  output logic         y,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] RELOAD_RST = W'(reload_rst(W));

  cnt_state_t   state, st_nxt;
  logic [W-1:0] reload_reg, cnt_nxt, rld_nxt;
  logic         y_nxt;

  dff_sync_n #(.W(W), .RST_VAL('0)) u_cnt (
    .clk(clk), .reset(reset), .d(cnt_nxt), .q(counter)
  );

  dff_sync_n #(.W(W), .RST_VAL(RELOAD_RST)) u_rld (
    .clk(clk), .reset(reset), .d(rld_nxt), .q(reload_reg)
  );

  // load beats pause, pause beats start; pause also holds IDLE/DONE.
  always_comb begin
    cnt_nxt = counter;
    rld_nxt = reload_reg;
    st_nxt  = state;
    y_nxt   = y;
    if (load) begin
      cnt_nxt = load_val;
      rld_nxt = load_val;
      st_nxt  = IDLE;
      y_nxt   = 1'b0;
    end else if (!pause) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt_nxt = reload_reg;
            st_nxt  = RUN;
            y_nxt   = (reload_reg == '0);
          end
        end
        RUN: begin
          if (counter != '0) begin
            cnt_nxt = counter - 1'b1;
            y_nxt   = (counter == W'(1));
          end else if (auto_reload) begin
            cnt_nxt = reload_reg;
            y_nxt   = (reload_reg == '0);
          end else begin
            st_nxt  = DONE;
            y_nxt   = 1'b0;
          end
        end
        default: begin
          st_nxt = IDLE;
          y_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      y     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= st_nxt;
      y     <= y_nxt;
      busy  <= (st_nxt == RUN);
      done  <= (st_nxt == DONE);
    end
  end

endmodule

// File: doc/down_cnt_timer.md
Name: down_cnt_timer

Overview:
- Loadable W-bit down-counter/timer; the count-down counterpart to the team's DFF-based up counter.
- Counts from a programmed value to zero and flags the terminal count on y.
- Optional auto-reload gives periodic ticks; a busy/done handshake lets a controlling FSM start it and wait for expiry.
- Sits beside the up counter in the demo designs, driving board LEDs from counter/y.

Parameters:
W, 3, counter width in bits (legal range 2..16)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
load  input  1  write load_val into counter and reload register
load_val  input  W  value for load
start  input  1  begin a count-down from the reload register
pause  input  1  freeze counting while high
auto_reload  input  1  sampled at terminal cycle: 1 = restart from reload register, 0 = stop
counter  output  W  current count, registered
y  output  1  terminal-count flag: high while in RUN with counter==0
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clk, reset port is reset.
- Reset (reset==0 at a posedge):
  - state=IDLE, counter=0, reload_reg=2^W-1.
  - y=0, busy=0, done=0.
  - Overrides every other input.
- All outputs registered; no combinational input->output paths.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1, busy=0.
- Priority each edge: reset > load > pause > start.
- load, in any state:
  - counter<=load_val, reload_reg<=load_val, state<=IDLE, y<=0.
  - Aborts a RUN in progress; done/busy clear.
- IDLE or DONE, start=1 (no load):
  - counter<=reload_reg, state<=RUN.
  - y<=1 if reload_reg==0.
- RUN, pause=1: counter, y and state hold unchanged, including when paused on the terminal cycle.
- RUN, pause=0, counter!=0:
  - counter<=counter-1.
  - y<=1 when the new value is 0.
  - Decrement never wraps below 0.
- RUN, pause=0, counter==0 (terminal cycle ends):
  - auto_reload=1: counter<=reload_reg, y<=(reload_reg==0), stay RUN. Period = reload_reg+1 cycles, with y high 1 cycle per period.
  - auto_reload=0: state<=DONE, counter holds 0, y<=0.
- start while in RUN is ignored.
- start in DONE restarts a new count-down (no need to pass through IDLE).
- reload_reg==0 with auto_reload=1: y stays high continuously in RUN. This is legal.
- Reset asserted mid-RUN: next cycle all outputs at reset values; reload_reg also restored to 2^W-1.
- Latency:
  - start to first decrement visible on counter: 2 edges.
  - load_val to counter: 1 edge.

Decomposition:
- Shared package (demo_pkg): state enum cnt_state_t {IDLE, RUN, DONE}; constant RELOAD_RST = all-ones of W, as a function of W.
- Sub-module dff_sync_n: W-bit register with synchronous active-low reset and parameterised reset value.
  - Used twice: counter and reload_reg.
  - Next-state logic stays in down_cnt_timer.

Test Plan:
- Reset values: hold reset=0 for 2 edges with load=1, start=1 -> counter=0, y=0, busy=0, done=0; start after release counts from 7 (7,6,...,0).
- One-shot: load 5, then start, auto_reload=0 -> counter 5,4,3,2,1,0 on consecutive cycles; y=1 only in the cycle showing 0; next cycle done=1, busy=0, counter=0.
- Auto-reload: load 2, start, auto_reload=1 -> counter 2,1,0,2,1,0,...; y high exactly every 3rd cycle; busy stays 1 for 12 cycles.
- Pause: load 4, start, pause=1 for 3 cycles when counter==2 -> counter holds 2 for those cycles, then resumes 1,0; pause at counter==0 keeps y=1 for the paused cycles.
- Abort and reset: load 6, start, load 3 while counter==4 -> next cycle counter=3, IDLE, busy=0. Start again, then reset=0 while counter==1 -> counter=0, all flags 0.
- Zero reload: load 0, start -> next cycle counter=0, y=1, busy=1. With auto_reload=0, DONE one cycle later. With auto_reload=1, y stays 1.
